// File: rtl/sram_responder_if.sv
// Request bus between the cache controller and the SRAM responder.
// Latency: none, signal bundle only.
// Backpressure: requester holds wr_en/rd_en until ready is seen high.
interface sram_responder_if;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [63:0] read_data;
    logic        ready;

    modport master (
        output wr_en, rd_en, address, write_data,
        input  read_data, ready
    );

    modport slave (
        input  wr_en, rd_en, address, write_data,
        output read_data, ready
    );
endinterface

// File: rtl/sram_responder.sv
// Serves 32-bit writes and 64-bit line reads against an async SRAM with fixed wait states.
// Latency: request sampled at edge 0, ready high in cycle WAIT_CYCLES+1 (one DONE cycle).
// Backpressure: ready low while an access is in flight; requester must hold its request until ready.
module sram_responder #(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    sram_responder_if.slave bus,
    inout  wire  [63:0] SRAM_DQ,
    output logic [16:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last counter value of an access; the access lasts WAIT_CYCLES cycles.
    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [31:0] addr_q,  addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [63:0] rdata_q, rdata_d;
    logic        ready_c;

    logic [31:0] word_off;
    logic        unused_off_bits;

    // Byte address to SRAM word: offset wraps modulo 2^32, byte lane bits dropped.
    assign word_off        = addr_q - BASE_ADDR;
    assign SRAM_ADDR       = word_off[18:2];
    assign unused_off_bits = ^{word_off[31:19], word_off[1:0]};

    // Strobes come straight from the registered state so WE_N cannot glitch.
    assign SRAM_WE_N = (state_q != ST_WRITE);
    assign SRAM_DQ   = (state_q == ST_WRITE) ? {32'b0, wdata_q} : 64'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

    assign bus.ready     = ready_c;
    assign bus.read_data = rdata_q;

    // Next-state, counter and latch logic; ready is combinational so the first request cycle shows ready=0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_c = ~(bus.wr_en | bus.rd_en);
                if (bus.wr_en) begin
                    state_d = ST_WRITE;
                    addr_d  = bus.address;
                    wdata_d = bus.write_data;
                    cnt_d   = 4'd0;
                end else if (bus.rd_en) begin
                    state_d = ST_READ;
                    addr_d  = bus.address;
                    cnt_d   = 4'd0;
                end
            end
            ST_WRITE: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_READ: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                    rdata_d = SRAM_DQ;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                ready_c = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; synchronous reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

endmodule
